fb_wr_sched: RTL and testbench
==============================

# fb_wr_sched

Write-port scheduler for the SPI-LCD framebuffer (135×240 pixels, 3 bytes per pixel, simple-dual-port BRAM). It shares the BRAM write port between two pixel writers (m0 = GPU raster, m1 = CPU bus) using round-robin arbitration. It also contains a fill engine that clears or paints the whole framebuffer to one colour. The read port stays owned by the LCD scan-out and is not touched by this block.

## Interface
Parameters:
- DP, 32400 — framebuffer depth in pixels (135*240).
- DW, 8 — bits per byte lane.
- N, 3 — byte lanes per pixel; pixel width PW = DW*N.
- AW, $clog2(DP) — address width (15 at defaults).

Ports:
- clk  in  1  — system clock; the single clock of the block.
- rstn  in  1  — reset, asynchronous, active-low.
- m0_valid / m1_valid  in  1 — write request.
- m0_ready / m1_ready  out  1 — request accepted this cycle.
- m0_addr / m1_addr  in  AW — pixel address.
- m0_data / m1_data  in  PW — pixel value.
- fill_start  in  1 — start a fill; single-cycle pulse.
- fill_color  in  PW — fill value; sampled with fill_start.
- fill_busy  out  1 — fill in progress.
- fill_done  out  1 — one-cycle pulse when the fill completes.
- err_oor  out  1 — one-cycle pulse when an accepted request has addr ≥ DP.
- bram_cea  out  1 — BRAM write enable.
- bram_addra  out  AW — BRAM write address.
- bram_dina  out  PW — BRAM write data.

## Operation
- FSM states:
  - IDLE: arbitrate m0/m1. fill_start=1 → FILL; latch fill_color; clear the counter.
  - FILL: issue one write per cycle at addresses 0..DP-1 with the latched colour. After issuing DP-1 → IDLE.
  - fill_start while in FILL is ignored.
- In FILL, m0_ready = m1_ready = 0. Requests wait and are not dropped.
- In IDLE, handshake rule: mX_ready is combinational from state, both valids, and the rr pointer. A transfer happens when valid & ready. Ready may depend on valid. Requesters must hold valid/addr/data until accepted.
- Round-robin arbitration:
  - Only one valid → that requester is granted.
  - Both valid → grant the one not granted last; update the rr pointer on every grant.
  - After reset, m0 wins the first tie.
- At most one grant per cycle.
- Out-of-range (addr ≥ DP):
  - The handshake completes (ready=1), so the requester is never stalled.
  - No BRAM write: bram_cea stays 0.
  - err_oor pulses with the same timing a write would have had.
- Address compare is unsigned AW-bit. The fill counter is AW bits, and its terminal value is DP-1, not 2^AW-1.

## Timing
- Reset value of every output is 0: bram_cea, bram_addra, bram_dina, fill_busy, fill_done, err_oor. m*_ready is 0 while rstn=0. rr pointer → m0 preferred.
- BRAM outputs are registered. A handshake in cycle t appears on bram_* in cycle t+1 with bram_cea=1 for exactly one cycle.
- Fill sequence, with fill_start sampled in cycle t:
  - State FILL and fill_busy=1 from t+1.
  - Address k is issued internally in cycle t+1+k and appears on bram_* at t+2+k.
  - The last issue is at t+DP.
  - At t+DP+1: state IDLE, fill_busy=0, fill_done=1 for one cycle, and ready may be high again.
  - Total: DP back-to-back bram writes with no gaps.
- fill_start and a request in the same IDLE cycle: the request is accepted in that cycle, so its write precedes fill address 0.
- Reset asserted mid-fill: immediate return to IDLE with all outputs 0. No fill_done pulse. BRAM contents are left partially filled.
- Sustained throughput is one write per cycle. With both requesters saturated, each gets 50%.

## Structure
- Package fb_pkg holds:
  - DP/DW/N defaults and derived PW/AW.
  - The FSM state enum {IDLE, FILL}.
  - The shared pixel type, so top-level SDPBRAM3 instantiation and the LCD path use the same widths.
- Sub-module rr_arb2: a 2-requester round-robin arbiter with valid inputs, grant outputs, and an advance strobe, plus a pointer register. It is reused later for read-port sharing.
- The fill counter, FSM, and output registers live in fb_wr_sched.

## Test plan
- Reset release, no traffic → all outputs 0 for 10 cycles; bram_cea never rises.
- m0 alone writes addr 5, data 0x123456 → m0_ready same cycle; next cycle bram_cea=1, addra=5, dina=0x123456.
- m0 and m1 held valid for 6 cycles → grants alternate m0,m1,m0,m1,m0,m1; 6 consecutive bram writes.
- fill_start with colour 0x00FF00, m1 valid throughout:
  - m1_ready=0 for DP cycles.
  - Exactly 32400 writes, addresses 0..32399, all 0x00FF00.
  - fill_done pulse once.
  - m1 accepted the cycle after the last fill write issue.
- m1 writes addr 32400 → accepted; bram_cea=0; err_oor=1 one cycle later.
- rstn pulsed low at fill address 1000 → outputs 0 asynchronously; after release the state is IDLE, fill_done never pulses, and a new fill restarts at address 0.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_pkg
// Purpose  : Shared framebuffer geometry, pixel type and write-scheduler
//            FSM state encoding for the SPI-LCD framebuffer path.
// Revision : 1.0 - initial release
// ============================================================================
package fb_pkg;

  // 135 x 240 panel, 3 bytes per pixel
  localparam int FB_DP = 32400;
  localparam int FB_DW = 8;
  localparam int FB_N  = 3;
  localparam int FB_PW = FB_DW * FB_N;
  localparam int FB_AW = $clog2(FB_DP);

  // Pixel word shared by the BRAM instance and the LCD scan-out path
  typedef logic [FB_PW-1:0] pixel_t;

  // Write-port scheduler states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fb_state_e;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter. Grants are combinational
//            from the requests and a one-bit priority pointer; the pointer
//            moves away from the granted requester when o_gnt is consumed
//            (i_adv high).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic r_pref1;

  // Grant the lone requester, or on a tie the one favoured by the pointer
  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = r_pref1 ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

  // After every consumed grant, favour the requester that did not win
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pref1 <= 1'b0;
    end else if (i_adv && (o_gnt != 2'b00)) begin
      r_pref1 <= o_gnt[0];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fb_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : fb_wr_sched
// Purpose  : Framebuffer BRAM write-port scheduler. Round-robin shares the
//            write port between two pixel writers and provides a fill engine
//            that paints every pixel with one colour. BRAM outputs are
//            registered: a handshake in cycle t writes in cycle t+1.
// Revision : 1.0 - initial release
// ============================================================================
module fb_wr_sched
  import fb_pkg::*;
#(
  parameter  int DP = FB_DP,
  parameter  int DW = FB_DW,
  parameter  int N  = FB_N,
  parameter  int AW = $clog2(DP),
  localparam int PW = DW * N
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic [AW-1:0] m0_addr,
  input  logic [PW-1:0] m0_data,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic [AW-1:0] m1_addr,
  input  logic [PW-1:0] m1_data,
  input  logic          fill_start,
  input  logic [PW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          err_oor,
  output logic          bram_cea,
  output logic [AW-1:0] bram_addra,
  output logic [PW-1:0] bram_dina
);

  // One extra bit so the range compare stays correct even when DP == 2**AW
  localparam logic [AW:0]   c_dp_ext    = (AW+1)'(DP);
  localparam logic [AW-1:0] c_last_addr = AW'(DP - 1);

  fb_state_e     r_state;
  fb_state_e     w_state_nxt;
  logic [AW-1:0] r_cnt;
  logic [PW-1:0] r_color;
  logic          r_cea;
  logic [AW-1:0] r_addra;
  logic [PW-1:0] r_dina;
  logic          r_done;
  logic          r_err;

  logic          w_idle;
  logic [1:0]    w_gnt;
  logic          w_acc;
  logic [AW-1:0] w_addr;
  logic [PW-1:0] w_data;
  logic          w_in_range;
  logic          w_fill_last;

  assign w_idle      = (r_state == IDLE);
  assign w_fill_last = (r_state == FILL) && (r_cnt == c_last_addr);

  rr_arb2 u_arb (
    .clk   (clk),
    .rstn  (rstn),
    .i_req ({m1_valid, m0_valid}),
    .i_adv (w_acc),
    .o_gnt (w_gnt)
  );

  // Ready only in IDLE and never while reset is held
  assign m0_ready = rstn & w_idle & w_gnt[0];
  assign m1_ready = rstn & w_idle & w_gnt[1];
  assign w_acc    = m0_ready | m1_ready;

  assign w_addr     = m1_ready ? m1_addr : m0_addr;
  assign w_data     = m1_ready ? m1_data : m0_data;
  assign w_in_range = ({1'b0, w_addr} < c_dp_ext);

  // Next-state logic: a fill starts from IDLE and ends after address DP-1
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (fill_start) w_state_nxt = FILL;
      FILL:    if (w_fill_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fill address counter and colour latch (colour sampled with fill_start)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_color <= '0;
    end else if (w_idle && fill_start) begin
      r_cnt   <= '0;
      r_color <= fill_color;
    end else if (!w_idle && !w_fill_last) begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  // Registered BRAM port plus the done and out-of-range pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_fill_last;
      r_err  <= w_acc & ~w_in_range;
      if (!w_idle) begin
        r_cea   <= 1'b1;
        r_addra <= r_cnt;
        r_dina  <= r_color;
      end else begin
        r_cea <= w_acc & w_in_range;
        if (w_acc && w_in_range) begin
          r_addra <= w_addr;
          r_dina  <= w_data;
        end
      end
    end
  end

  assign fill_busy  = ~w_idle;
  assign fill_done  = r_done;
  assign err_oor    = r_err;
  assign bram_cea   = r_cea;
  assign bram_addra = r_addra;
  assign bram_dina  = r_dina;

endmodule : fb_wr_sched
`default_nettype wire

// File: tb/tb_fb_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fb_wr_sched
// Purpose  : Self-checking bench for fb_wr_sched. Expected BRAM writes are
//            queued when the stimulus is driven and popped when the DUT
//            writes; handshake, busy, done and error outputs are predicted
//            by a small cycle model of the arbiter and fill engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_wr_sched;

  localparam int DP = 32400;
  localparam int AW = 15;
  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rstn;
  logic          m0_valid, m0_ready, m1_valid, m1_ready;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [PW-1:0] m0_data, m1_data;
  logic          fill_start;
  logic [PW-1:0] fill_color;
  logic          fill_busy, fill_done, err_oor, bram_cea;
  logic [AW-1:0] bram_addra;
  logic [PW-1:0] bram_dina;

  always #5 clk = ~clk;

  fb_wr_sched #(.DP(DP), .DW(8), .N(3), .AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .m0_valid   (m0_valid),
    .m0_ready   (m0_ready),
    .m0_addr    (m0_addr),
    .m0_data    (m0_data),
    .m1_valid   (m1_valid),
    .m1_ready   (m1_ready),
    .m1_addr    (m1_addr),
    .m1_data    (m1_data),
    .fill_start (fill_start),
    .fill_color (fill_color),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .err_oor    (err_oor),
    .bram_cea   (bram_cea),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  n_done = 0;

  // Cycle model state
  int  fill_rem  = 0;
  bit  done_next = 1'b0;
  bit  oor_next  = 1'b0;
  bit  pref1     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every BRAM write must match the head of the expected queue
  always @(negedge clk) begin : p_mon
    wr_t e;
    if (rstn === 1'b1) begin
      if (fill_done === 1'b1) n_done++;
      if (bram_cea !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'(bram_cea), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bram_addra), 32'(e.addr));
          chk("wr_data", 32'(bram_dina), 32'(e.data));
        end
      end
    end
  end

  // One clock of stimulus; checks status outputs against the model
  task automatic drive(input bit v0, input logic [AW-1:0] a0, input logic [PW-1:0] d0,
                       input bit v1, input logic [AW-1:0] a1, input logic [PW-1:0] d1,
                       input bit fs, input logic [PW-1:0] fc);
    bit            idle, e0, e1;
    logic [AW-1:0] a;
    logic [PW-1:0] d;
    @(negedge clk);
    m0_valid = v0; m0_addr = a0; m0_data = d0;
    m1_valid = v1; m1_addr = a1; m1_data = d1;
    fill_start = fs; fill_color = fc;
    #1;
    idle = (fill_rem == 0);
    chk("fill_busy", 32'(fill_busy), 32'(!idle));
    chk("fill_done", 32'(fill_done), 32'(done_next));
    chk("err_oor",   32'(err_oor),   32'(oor_next));
    done_next = 1'b0;
    oor_next  = 1'b0;
    e0 = 1'b0;
    e1 = 1'b0;
    if (idle) begin
      if (v0 && v1) begin
        if (pref1) e1 = 1'b1; else e0 = 1'b1;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk("m0_ready", 32'(m0_ready), 32'(e0));
    chk("m1_ready", 32'(m1_ready), 32'(e1));
    if (e0 || e1) begin
      pref1 = e0;
      a = e1 ? a1 : a0;
      d = e1 ? d1 : d0;
      if (int'(a) < DP) exp_q.push_back({a, d});
      else oor_next = 1'b1;
    end
    if (idle && fs) begin
      fill_rem = DP;
      for (int k = 0; k < DP; k++) exp_q.push_back({AW'(k), fc});
    end else if (!idle) begin
      fill_rem--;
      if (fill_rem == 0) done_next = 1'b1;
    end
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, '0, 0, '0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m0_ready"},  32'(m0_ready),   32'd0);
    chk({tag, "_m1_ready"},  32'(m1_ready),   32'd0);
    chk({tag, "_cea"},       32'(bram_cea),   32'd0);
    chk({tag, "_addra"},     32'(bram_addra), 32'd0);
    chk({tag, "_dina"},      32'(bram_dina),  32'd0);
    chk({tag, "_fill_busy"}, 32'(fill_busy),  32'd0);
    chk({tag, "_fill_done"}, 32'(fill_done),  32'd0);
    chk({tag, "_err_oor"},   32'(err_oor),    32'd0);
  endtask

  // Hard time limit so a stuck design still produces the summary
  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded its time budget");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int  i0, i1, stall;
    bit  got, found;
    rstn = 1'b1;
    m0_valid = 1'b1; m0_addr = '0; m0_data = '0;
    m1_valid = 1'b1; m1_addr = '0; m1_data = '0;
    fill_start = 1'b0; fill_color = '0;
    #1 rstn = 1'b0;
    #11;
    chk_all_zero("rst");
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Quiet after reset
    for (int c = 0; c < 10; c++) begin
      idle_cyc(1);
      chk("idle_cea", 32'(bram_cea), 32'd0);
    end

    // Both requesters saturated: strict alternation starting with m0
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, AW'(10 + i0), PW'(24'hA00000 + i0), 1, AW'(20 + i1), PW'(24'hB00000 + i1), 0, '0);
      chk("rr_order", {30'd0, m1_ready, m0_ready}, (c % 2) ? 32'd2 : 32'd1);
      if (m0_ready) i0++;
      if (m1_ready) i1++;
    end
    idle_cyc(3);

    // Single writer
    drive(1, AW'(5), 24'h123456, 0, '0, '0, 0, '0);
    chk("m0_alone_ready", 32'(m0_ready), 32'd1);
    idle_cyc(3);

    // Fill with m1 waiting; a second fill_start mid-fill is ignored
    drive(0, '0, '0, 0, '0, '0, 1, 24'h00FF00);
    stall = 0;
    got   = 1'b0;
    for (int c = 0; c < DP + 10 && !got; c++) begin
      drive(0, '0, '0, 1, AW'(100), 24'hC0FFEE, c == 50, 24'hFFFFFF);
      if (m1_ready === 1'b1) got = 1'b1;
      else stall++;
    end
    chk("fill_m1_accepted", 32'(got), 32'd1);
    chk("fill_stall_cycles", 32'(stall), 32'(DP));
    idle_cyc(3);

    // Out-of-range write: handshake completes, error pulse, no BRAM write
    drive(0, '0, '0, 1, AW'(DP), 24'hDEAD01, 0, '0);
    chk("oor_ready", 32'(m1_ready), 32'd1);
    idle_cyc(1);
    chk("oor_err", 32'(err_oor), 32'd1);
    chk("oor_cea", 32'(bram_cea), 32'd0);
    idle_cyc(2);

    // Request and fill_start together: request writes first
    drive(1, AW'(7), 24'h777777, 0, '0, '0, 1, 24'h0000FF);
    chk("fs_req_ready", 32'(m0_ready), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 3000 && !found; c++) begin
      idle_cyc(1);
      if (bram_cea === 1'b1 && bram_addra == AW'(1000)) found = 1'b1;
    end
    chk("fill_reached_1000", 32'(found), 32'd1);

    // Asynchronous reset in the middle of the fill
    #2 rstn = 1'b0;
    #1;
    chk_all_zero("midfill_rst");
    exp_q.delete();
    fill_rem  = 0;
    done_next = 1'b0;
    oor_next  = 1'b0;
    pref1     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle_cyc(3);

    // Fresh fill restarts at address 0 and runs to completion
    drive(0, '0, '0, 0, '0, '0, 1, 24'h123ABC);
    idle_cyc(DP + 5);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("done_pulses", 32'(n_done), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fb_wr_sched
`default_nettype wire
